// File: rtl/sm_add_if.sv
// sm_add_if: handshake bundle for the sign-magnitude adder/accumulator.
//   Input side : in_valid, in_ready, mode, last, a, b
//   Output side: out_valid, out_ready, c, ovf
//   master = the block driving operands and consuming results
//   slave  = the adder/accumulator itself
interface sm_add_if #(
    parameter int N = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic         last;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         ovf;

    modport master (
        output in_valid, mode, last, a, b, out_ready,
        input  in_ready, out_valid, c, ovf
    );

    modport slave (
        input  in_valid, mode, last, a, b, out_ready,
        output in_ready, out_valid, c, ovf
    );
endinterface

// File: rtl/sm_add_acc.sv
// sm_add_acc: two-stage pipelined sign-magnitude adder / frame accumulator.
//   Words are sign-magnitude: bit N-1 = sign, bits N-2:0 = magnitude.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - sm_add_if slave: in_valid/in_ready/mode/last/a/b in,
//            out_valid/out_ready/c/ovf out
//   mode=0 (ADD): c = a + b, one result per beat.
//   mode=1 (ACC): a is summed into a running accumulator; the beat with
//   last=1 emits the frame total and clears the accumulator.
//   SAT=1 clamps the magnitude on overflow, SAT=0 drops the carry.
module sm_add_acc #(
    parameter int N   = 16,
    parameter bit SAT = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    sm_add_if.slave  bus
);

    // Returns {overflow, sign, magnitude}. Negative zero is treated as +0 on
    // input, and a zero magnitude always comes out with a positive sign.
    function automatic logic [N:0] sm_add(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-2:0] mx, my, mag;
        logic         sx, sy, sgn, of;
        logic [N-1:0] sum;
        mx  = x[N-2:0];
        my  = y[N-2:0];
        sx  = x[N-1] && (mx != '0);
        sy  = y[N-1] && (my != '0);
        of  = 1'b0;
        sum = '0;
        if (sx == sy) begin
            sum = {1'b0, mx} + {1'b0, my};
            of  = sum[N-1];
            mag = sum[N-2:0];
            sgn = sx;
            if (of) mag = sat_mag(mag);
        end else if (mx >= my) begin
            mag = mx - my;
            sgn = sx;
        end else begin
            mag = my - mx;
            sgn = sy;
        end
        if (mag == '0) sgn = 1'b0;
        return {of, sgn, mag};
    endfunction

    // Overflowed magnitude: clamp to full scale, or keep the wrapped bits.
    function automatic logic [N-2:0] sat_mag(input logic [N-2:0] wrapped);
        return SAT ? {(N-1){1'b1}} : wrapped;
    endfunction

    logic         vld_p1;
    logic         mode_p1;
    logic         last_p1;
    logic [N-1:0] a_p1;
    logic [N-1:0] b_p1;

    logic [N-1:0] acc;
    logic         acc_ovf;

    logic         out_valid_r;
    logic [N-1:0] c_r;
    logic         ovf_r;

    logic [N:0]   res_p1;
    logic         emits_p1;
    logic         s2_adv;
    logic         in_fire;

    // ACC beats without last only touch the accumulator, so they never wait
    // on the output register.
    assign emits_p1 = !mode_p1 || last_p1;
    assign s2_adv   = vld_p1 && (!out_valid_r || bus.out_ready || !emits_p1);
    assign bus.in_ready = !rst && (!vld_p1 || s2_adv);
    assign in_fire  = bus.in_valid && bus.in_ready;

    assign res_p1   = sm_add(a_p1, mode_p1 ? acc : b_p1);

    assign bus.out_valid = out_valid_r;
    assign bus.c         = c_r;
    assign bus.ovf       = ovf_r;

    // stage 1: operand capture
    always_ff @(posedge clk) begin
        if (in_fire) begin
            a_p1    <= bus.a;
            b_p1    <= bus.b;
            mode_p1 <= bus.mode;
            last_p1 <= bus.last;
        end
    end

    // stage 2: add, accumulate, output register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            out_valid_r <= 1'b0;
            c_r         <= '0;
            ovf_r       <= 1'b0;
            acc         <= '0;
            acc_ovf     <= 1'b0;
        end else begin
            if (in_fire)     vld_p1 <= 1'b1;
            else if (s2_adv) vld_p1 <= 1'b0;

            if (out_valid_r && bus.out_ready) out_valid_r <= 1'b0;

            if (s2_adv) begin
                if (emits_p1) begin
                    c_r         <= res_p1[N-1:0];
                    ovf_r       <= res_p1[N] || (mode_p1 && acc_ovf);
                    out_valid_r <= 1'b1;
                end
                if (mode_p1) begin
                    if (last_p1) begin
                        acc     <= '0;
                        acc_ovf <= 1'b0;
                    end else begin
                        acc     <= res_p1[N-1:0];
                        acc_ovf <= acc_ovf || res_p1[N];
                    end
                end
            end
        end
    end

endmodule
